// File: rtl/rs_scheduler.sv
// Reservation station: buffers issued ops until both operands are ready, then dispatches one per cycle.
// Optional macro RS_AGE_SELECT_EN selects the oldest eligible entry; otherwise the lowest index wins.
module rs_scheduler #(
    parameter int RS_SIZE    = 8,
    parameter int VAL_WIDTH  = 32,
    parameter int TAG_WIDTH  = 5,
    parameter int OP_WIDTH   = 7,
    parameter int WAKE_PORTS = 3
) (
    input  logic                            clk,
    input  logic                            rst_in_n,
    input  logic                            rdy_in,
    input  logic                            flush,
    input  logic                            issue_valid,
    output logic                            issue_ready,
    input  logic [OP_WIDTH-1:0]             issue_op,
    input  logic [TAG_WIDTH-1:0]            issue_tag,
    input  logic [TAG_WIDTH-1:0]            issue_q1,
    input  logic [TAG_WIDTH-1:0]            issue_q2,
    input  logic [VAL_WIDTH-1:0]            issue_v1,
    input  logic [VAL_WIDTH-1:0]            issue_v2,
    input  logic [WAKE_PORTS-1:0]           wake_en,
    input  logic [WAKE_PORTS*TAG_WIDTH-1:0] wake_tag,
    input  logic [WAKE_PORTS*VAL_WIDTH-1:0] wake_val,
    output logic                            disp_valid,
    input  logic                            disp_ready,
    output logic [OP_WIDTH-1:0]             disp_op,
    output logic [TAG_WIDTH-1:0]            disp_tag,
    output logic [VAL_WIDTH-1:0]            disp_v1,
    output logic [VAL_WIDTH-1:0]            disp_v2,
    output logic [$clog2(RS_SIZE+1)-1:0]    count
);

    localparam int CW = $clog2(RS_SIZE + 1);
    localparam int IW = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0]   busy;
    logic [OP_WIDTH-1:0]  e_op  [RS_SIZE];
    logic [TAG_WIDTH-1:0] e_tag [RS_SIZE];
    logic [TAG_WIDTH-1:0] e_q1  [RS_SIZE];
    logic [TAG_WIDTH-1:0] e_q2  [RS_SIZE];
    logic [VAL_WIDTH-1:0] e_v1  [RS_SIZE];
    logic [VAL_WIDTH-1:0] e_v2  [RS_SIZE];

    logic [RS_SIZE-1:0]   elig;
    logic [IW-1:0]        free_idx;
    logic [IW-1:0]        sel_idx;
    logic                 sel_found;
    logic                 out_free;
    logic                 move;
    logic                 do_issue;
    logic [VAL_WIDTH:0]   wk1 [RS_SIZE];
    logic [VAL_WIDTH:0]   wk2 [RS_SIZE];
    logic [VAL_WIDTH:0]   byp1;
    logic [VAL_WIDTH:0]   byp2;

`ifdef RS_AGE_SELECT_EN
    // older[j][i] set means entry j was issued before entry i
    logic [RS_SIZE-1:0] older [RS_SIZE];
    logic               blocked;
`endif

    // Returns {hit, value}; the lowest-numbered matching port takes priority.
    function automatic logic [VAL_WIDTH:0] lookup(
        input logic [TAG_WIDTH-1:0]            q,
        input logic [WAKE_PORTS-1:0]           en,
        input logic [WAKE_PORTS*TAG_WIDTH-1:0] tags,
        input logic [WAKE_PORTS*VAL_WIDTH-1:0] vals
    );
        logic [VAL_WIDTH:0] r;
        r = '0;
        for (int p = WAKE_PORTS - 1; p >= 0; p--) begin
            if (en[p] && (q != '0) && (tags[p*TAG_WIDTH +: TAG_WIDTH] == q))
                r = {1'b1, vals[p*VAL_WIDTH +: VAL_WIDTH]};
        end
        return r;
    endfunction

    assign issue_ready = (count != CW'(RS_SIZE));
    assign do_issue    = issue_valid && issue_ready;
    assign out_free    = !disp_valid || disp_ready;
    assign move        = sel_found && out_free;
    assign byp1        = lookup(issue_q1, wake_en, wake_tag, wake_val);
    assign byp2        = lookup(issue_q2, wake_en, wake_tag, wake_val);

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            elig[i] = busy[i] && (e_q1[i] == '0) && (e_q2[i] == '0);
            wk1[i]  = lookup(e_q1[i], wake_en, wake_tag, wake_val);
            wk2[i]  = lookup(e_q2[i], wake_en, wake_tag, wake_val);
        end
    end

    always_comb begin
        free_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i])
                free_idx = IW'(i);
        end
    end

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
`ifdef RS_AGE_SELECT_EN
        blocked   = 1'b0;
`endif
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
`ifdef RS_AGE_SELECT_EN
            blocked = 1'b0;
            for (int j = 0; j < RS_SIZE; j++) begin
                if (elig[j] && older[j][i])
                    blocked = 1'b1;
            end
            if (elig[i] && !blocked) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
`else
            if (elig[i]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            busy       <= '0;
            count      <= '0;
            disp_valid <= 1'b0;
            disp_op    <= '0;
            disp_tag   <= '0;
            disp_v1    <= '0;
            disp_v2    <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                e_op[i]  <= '0;
                e_tag[i] <= '0;
                e_q1[i]  <= '0;
                e_q2[i]  <= '0;
                e_v1[i]  <= '0;
                e_v2[i]  <= '0;
`ifdef RS_AGE_SELECT_EN
                older[i] <= '0;
`endif
            end
        end else if (rdy_in) begin
            if (flush) begin
                busy       <= '0;
                count      <= '0;
                disp_valid <= 1'b0;
                for (int i = 0; i < RS_SIZE; i++) begin
                    e_q1[i] <= '0;
                    e_q2[i] <= '0;
                end
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy[i] && wk1[i][VAL_WIDTH]) begin
                        e_q1[i] <= '0;
                        e_v1[i] <= wk1[i][VAL_WIDTH-1:0];
                    end
                    if (busy[i] && wk2[i][VAL_WIDTH]) begin
                        e_q2[i] <= '0;
                        e_v2[i] <= wk2[i][VAL_WIDTH-1:0];
                    end
                end

                if (out_free) begin
                    disp_valid <= move;
                    if (move) begin
                        disp_op        <= e_op[sel_idx];
                        disp_tag       <= e_tag[sel_idx];
                        disp_v1        <= e_v1[sel_idx];
                        disp_v2        <= e_v2[sel_idx];
                        busy[sel_idx]  <= 1'b0;
                    end
                end

                // free_idx comes from start-of-cycle busy bits, so it never aliases sel_idx
                if (do_issue) begin
                    busy[free_idx]  <= 1'b1;
                    e_op[free_idx]  <= issue_op;
                    e_tag[free_idx] <= issue_tag;
                    e_q1[free_idx]  <= byp1[VAL_WIDTH] ? '0 : issue_q1;
                    e_v1[free_idx]  <= byp1[VAL_WIDTH] ? byp1[VAL_WIDTH-1:0] : issue_v1;
                    e_q2[free_idx]  <= byp2[VAL_WIDTH] ? '0 : issue_q2;
                    e_v2[free_idx]  <= byp2[VAL_WIDTH] ? byp2[VAL_WIDTH-1:0] : issue_v2;
`ifdef RS_AGE_SELECT_EN
                    older[free_idx] <= '0;
                    for (int i = 0; i < RS_SIZE; i++) begin
                        if (IW'(i) != free_idx)
                            older[i][free_idx] <= 1'b1;
                    end
`endif
                end

                count <= count + CW'(do_issue) - CW'(move);
            end
        end
    end

endmodule
